// File: rtl/dm_handshake_ctrl_if.sv
// ---------------------------------------------------------------------------
// dm_handshake_ctrl_if
// Request/acknowledge bundle between the CPU memory stage (master) and the
// wait-stated data memory (slave).
//   req    master->slave  access request, held until ack
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  byte address
//   wdata  master->slave  write data
//   be     master->slave  byte-lane enables (only when DM_BYTE_WR_EN is defined)
//   ack    slave->master  one-cycle completion pulse
//   err    slave->master  access rejected, valid with ack
//   rdata  slave->master  read data, valid with ack on a read and held after
//   busy   slave->master  controller is not idle
// ---------------------------------------------------------------------------
interface dm_handshake_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
`ifdef DM_BYTE_WR_EN
    logic [3:0]  be;
`endif
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        busy;

`ifdef DM_BYTE_WR_EN
    modport master (output req, we, addr, wdata, be, input ack, err, rdata, busy);
    modport slave  (input req, we, addr, wdata, be, output ack, err, rdata, busy);
`else
    modport master (output req, we, addr, wdata, input ack, err, rdata, busy);
    modport slave  (input req, we, addr, wdata, output ack, err, rdata, busy);
`endif
endinterface

// File: rtl/dm_handshake_ctrl.sv
// ---------------------------------------------------------------------------
// dm_handshake_ctrl
// Data memory of 2^ADDR_W 32-bit words behind a req/ack handshake with a
// programmable number of wait states. The CPU holds req until ack; the
// request fields are captured once in IDLE, so later changes are ignored.
// Misaligned or out-of-range byte addresses are rejected with err.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   dm_handshake_ctrl_if.slave (req/we/addr/wdata[/be] in,
//         ack/err/rdata/busy out)
//
// Parameters:
//   WAIT_CYCLES  extra wait states before the array access (0..15)
//   ADDR_W       word-address width
//
// Optional feature macro: DM_BYTE_WR_EN
//   Defined:   byte-lane write enables (bus.be); addr[1:0] ignored, only
//              the range check can raise err.
//   Undefined: full-word writes; misaligned addresses raise err.
// ---------------------------------------------------------------------------
module dm_handshake_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 10
) (
    input logic                 clk,
    input logic                 rst,
    dm_handshake_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          wait_cnt;
    logic [31:0]         lat_addr;
    logic                lat_we;
    logic [31:0]         lat_wdata;
`ifdef DM_BYTE_WR_EN
    logic [3:0]          lat_be;
`endif

    logic [31:0]         mem [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0]   word_idx;
    logic [31:0]         high_bits;
    logic                range_err;
    logic                align_err;
    logic                access_err;
    logic                access_now;
    logic                mem_we;

    // Error and access decode all work on the latched request, never on the
    // live bus, so the requester may change its outputs once we are busy.
    assign word_idx   = lat_addr[ADDR_W+1:2];
    assign high_bits  = lat_addr >> (ADDR_W + 2);
    assign range_err  = (high_bits != 32'd0);
`ifdef DM_BYTE_WR_EN
    assign align_err  = 1'b0;
`else
    assign align_err  = (lat_addr[1:0] != 2'b00);
`endif
    assign access_err = range_err | align_err;
    assign access_now = (state == S_WAIT) && (wait_cnt == 4'd0);
    assign mem_we     = access_now && lat_we && !access_err;

    // Handshake FSM. ack/err default low every cycle and are raised only on
    // the access edge, which gives the single-cycle pulse in RESP. busy is
    // registered alongside the state so it mirrors state != IDLE exactly.
    // Reset abandons any latched request; since mem_we depends on the state,
    // a write caught in WAIT is never performed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            lat_addr  <= 32'd0;
            lat_we    <= 1'b0;
            lat_wdata <= 32'd0;
`ifdef DM_BYTE_WR_EN
            lat_be    <= 4'd0;
`endif
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= 32'd0;
            bus.busy  <= 1'b0;
        end else begin
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        lat_addr  <= bus.addr;
                        lat_we    <= bus.we;
                        lat_wdata <= bus.wdata;
`ifdef DM_BYTE_WR_EN
                        lat_be    <= bus.be;
`endif
                        wait_cnt  <= 4'(WAIT_CYCLES);
                        state     <= S_WAIT;
                        bus.busy  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state   <= S_RESP;
                        bus.ack <= 1'b1;
                        bus.err <= access_err;
                        if (!lat_we && !access_err) begin
                            bus.rdata <= mem[word_idx];
                        end
                    end
                end
                S_RESP: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

    // Array write port. Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
`ifdef DM_BYTE_WR_EN
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
`else
            mem[word_idx] <= lat_wdata;
`endif
        end
    end

endmodule

// File: tb/tb_dm_handshake_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dm_handshake_ctrl
// Self-checking bench for dm_handshake_ctrl (WAIT_CYCLES = 2, ADDR_W = 10).
// Each request computes its expected response from a behavioural memory model
// and pushes it to a queue; a monitor pops and compares on every ack.
// ---------------------------------------------------------------------------
module tb_dm_handshake_ctrl;

    localparam int WAIT = 2;
    localparam int AW   = 10;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic rst;
    dm_handshake_ctrl_if bus();

    dm_handshake_ctrl #(.WAIT_CYCLES(WAIT), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t        exp_q[$];
    logic [31:0] model_mem [0:(2**AW)-1];
    logic [31:0] last_rdata;
    int          checks     = 0;
    int          errors     = 0;
    int          cyc        = 0;
    int          ack_count  = 0;

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Behavioural model of one access: returns the expected response and
    // updates the model memory / held read data.
    function automatic exp_t model_access(input logic is_write, input logic [31:0] a,
                                          input logic [31:0] d, input logic [3:0] byte_en);
        exp_t        e;
        logic [3:0]  mask;
        logic        bad;
        int          idx;
        idx = int'(a[AW+1:2]);
`ifdef DM_BYTE_WR_EN
        mask = byte_en;
        bad  = (a[31:AW+2] != '0);
`else
        mask = byte_en | 4'hF;
        bad  = (a[31:AW+2] != '0) || (a[1:0] != 2'b00);
`endif
        if (!bad && is_write) begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
        end else if (!bad) begin
            last_rdata = model_mem[idx];
        end
        e.err   = bad;
        e.rdata = last_rdata;
        return e;
    endfunction

    // Scoreboard monitor: compares every ack against the queue head, and
    // insists err stays low outside ack.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.ack) begin
                ack_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("resp_err", 32'(bus.err), 32'(e.err));
                    checkOutput("resp_rdata", bus.rdata, e.rdata);
                end
            end else begin
                checkOutput("err_without_ack", 32'(bus.err), 32'd0);
            end
        end
    end

    // Waits (bounded) for the next ack at a negedge; returns its cycle index.
    task automatic wait_ack(output int t, output bit seen);
        seen = 1'b0;
        t    = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.ack) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
    endtask

    // One full transaction. With mid_change set, the request fields are
    // scrambled and req dropped one cycle into WAIT.
    task automatic applyStimulus(input logic is_write, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] byte_en, input bit mid_change);
        int e0;
        bit seen;
        exp_q.push_back(model_access(is_write, a, d, byte_en));
        bus.req   = 1'b1;
        bus.we    = is_write;
        bus.addr  = a;
        bus.wdata = d;
`ifdef DM_BYTE_WR_EN
        bus.be    = byte_en;
`endif
        e0   = cyc + 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mid_change && cyc == e0) begin
                bus.req   = 1'b0;
                bus.addr  = a ^ 32'h0000_00C0;
                bus.we    = ~is_write;
                bus.wdata = ~d;
            end
            if (bus.ack) begin
                seen = 1'b1;
                checkOutput("ack_latency", 32'(cyc - e0), 32'(WAIT + 1));
            end else begin
                checkOutput("busy_during_access", 32'(bus.busy), 32'd1);
            end
        end
        if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
        bus.req = 1'b0;
        @(negedge clk);
        checkOutput("ack_one_cycle", 32'(bus.ack), 32'd0);
        checkOutput("busy_after_resp", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int  t1, t2, e0, acks_before;
        bit  seen;
        logic [31:0] a, d;

        rst       = 1'b0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;
`ifdef DM_BYTE_WR_EN
        bus.be    = 4'hF;
`endif
        last_rdata = 32'd0;
        for (int i = 0; i < 2**AW; i++) model_mem[i] = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ack", 32'(bus.ack), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        checkOutput("rst_rdata", bus.rdata, 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", 32'(bus.busy), 32'd0);

        // Reset during WAIT discards a pending write to 0x10
        applyStimulus(1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, 1'b0);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 32'h10;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        checkOutput("abort_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst     = 1'b0;
        bus.req = 1'b0;
        #1;
        checkOutput("abort_ack", 32'(bus.ack), 32'd0);
        checkOutput("abort_err", 32'(bus.err), 32'd0);
        checkOutput("abort_rdata", bus.rdata, 32'd0);
        checkOutput("abort_busy_rst", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        last_rdata = 32'd0;
        @(negedge clk);
        checkOutput("post_abort_busy", 32'(bus.busy), 32'd0);
        applyStimulus(1'b0, 32'h10, 32'd0, 4'hF, 1'b0);

        // Write then read
        applyStimulus(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0);
        applyStimulus(1'b0, 32'h40, 32'd0, 4'hF, 1'b0);

        // Back-to-back reads with req held high
        applyStimulus(1'b1, 32'h0, 32'h1111_2222, 4'hF, 1'b0);
        applyStimulus(1'b1, 32'h4, 32'h3333_4444, 4'hF, 1'b0);
        exp_q.push_back(model_access(1'b0, 32'h0, 32'd0, 4'hF));
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 32'h0;
        e0 = cyc + 1;
        wait_ack(t1, seen);
        checkOutput("b2b_first_latency", 32'(t1 - e0), 32'(WAIT + 1));
        bus.addr = 32'h4;
        exp_q.push_back(model_access(1'b0, 32'h4, 32'd0, 4'hF));
        wait_ack(t2, seen);
        checkOutput("b2b_spacing", 32'(t2 - t1), 32'(WAIT + 3));
        bus.req = 1'b0;
        @(negedge clk);

        // Misaligned write (or byte-lane write in byte mode)
`ifdef DM_BYTE_WR_EN
        applyStimulus(1'b1, 32'h40, 32'h00AA_0000, 4'b0100, 1'b0);
        applyStimulus(1'b1, 32'h44, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        applyStimulus(1'b0, 32'h44, 32'd0, 4'hF, 1'b0);
`else
        applyStimulus(1'b1, 32'h42, 32'h0BAD_0BAD, 4'hF, 1'b0);
        applyStimulus(1'b0, 32'h43, 32'd0, 4'hF, 1'b0);
`endif
        applyStimulus(1'b0, 32'h40, 32'd0, 4'hF, 1'b0);

        // Out of range: read holds rdata, write must not alias onto 0x40
        applyStimulus(1'b0, 32'h1000, 32'd0, 4'hF, 1'b0);
        applyStimulus(1'b1, 32'h1040, 32'h5A5A_5A5A, 4'hF, 1'b0);
        applyStimulus(1'b0, 32'h8000_0040, 32'd0, 4'hF, 1'b0);
        applyStimulus(1'b0, 32'h40, 32'd0, 4'hF, 1'b0);

        // Request fields change and req drops mid-access
        applyStimulus(1'b1, 32'h80, 32'h55AA_55AA, 4'hF, 1'b0);
        acks_before = ack_count;
        applyStimulus(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 1'b1);
        repeat (6) @(negedge clk);
        checkOutput("mid_change_single_ack", 32'(ack_count - acks_before), 32'd1);
        applyStimulus(1'b0, 32'h40, 32'd0, 4'hF, 1'b0);
        applyStimulus(1'b0, 32'h80, 32'd0, 4'hF, 1'b0);

        // Short random mix over a few words
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 32'(i * 4) + 32'h100, $urandom, 4'hF, 1'b0);
        for (int i = 0; i < 12; i++) begin
            a = 32'($urandom_range(0, 7) * 4) + 32'h100;
            if ($urandom_range(0, 5) == 0) a = a | 32'h0000_2000;
            d = $urandom;
            applyStimulus(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)), 1'b0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dm_handshake_ctrl.md
Name: dm_handshake_ctrl

Overview:
- Data-memory subsystem downstream of the multi-cycle CPU's memory stage.
- Replaces the zero-latency data-memory array with a 1024x32 word memory behind a req/ack handshake and a programmable wait-state counter.
- Lets the CPU FSM stall in its memory-load and memory-write states until the access completes.
- Flags bad accesses: misaligned or out-of-range addresses.

Parameters:
- WAIT_CYCLES, 2, extra wait states inserted before the array access (0..15).
- ADDR_W, 10, word-address width; memory depth is 2^ADDR_W words, so byte span is 2^(ADDR_W+2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  access request; held high by the requester until ack.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  32  byte address.
- wdata  in  32  write data.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; access rejected.
- rdata  out  32  read data; valid with ack on a read, held afterwards.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: clk is the clock; reset rst is asynchronous, active-low.
  - On reset: state = IDLE; ack = 0, err = 0, rdata = 0, busy = 0; wait counter = 0.
  - Any latched request is discarded; an in-flight write is NOT performed.
  - Array contents are not reset.
- FSM states and transitions:
  - IDLE: if req = 1 at edge E0, latch addr/we/wdata, load counter = WAIT_CYCLES, go to WAIT. Otherwise stay.
  - WAIT: if counter != 0, decrement it. If counter == 0, perform the access at this edge and go to RESP.
    - Write: array[addr[ADDR_W+1:2]] <= wdata.
    - Read: rdata <= array word.
  - RESP: ack = 1 (registered, one cycle); go to IDLE on the next edge regardless of req.
- Latency and throughput:
  - ack is high in the cycle after edge E0+WAIT_CYCLES+1.
  - ack drops after E0+WAIT_CYCLES+2.
  - A request held high through RESP is re-accepted in the following IDLE cycle. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles.
- Handshake rules:
  - Request fields are latched only in IDLE. Changes on addr/we/wdata while busy are ignored.
  - Dropping req mid-access does not cancel it; ack still pulses.
- Error rules, checked on the latched address at the access edge:
  - Misaligned: addr[1:0] != 0.
  - Out of range: addr[31:ADDR_W+2] != 0.
  - On error: no array write; rdata unchanged; err = 1 for the RESP cycle only. Error accesses take the same latency as good ones.
- Output timing:
  - err = 0 whenever ack = 0.
  - rdata changes only on a successful read access edge or on reset.
- Write-then-read to the same word in consecutive transactions returns the new data.

Optional Feature:
- Macro: DM_BYTE_WR_EN.
- Defined:
  - Adds input be [3:0], latched with req in IDLE.
  - Write updates only the byte lanes where be[i] = 1; be = 0 is a no-op write but still acks with err = 0.
  - addr[1:0] is ignored, so there is no misalignment error; range check only.
  - Reads always return the full word.
- Undefined:
  - No be port; writes are full-word; misaligned accesses raise err.

Test Plan (WAIT_CYCLES = 2, ADDR_W = 10):
- Reset: rst low while busy in WAIT with a pending write to 0x10 -> after release all outputs are 0 and a read of 0x10 does not return the discarded data.
- Write then read: req, we = 1, addr = 0x40, wdata = 0xDEADBEEF at E0 -> ack in the cycle after E3, busy high E0..E3, err = 0; then a read of 0x40 -> rdata = 0xDEADBEEF with ack.
- Back-to-back: req held high for reads of 0x0 then 0x4 -> two ack pulses exactly 5 cycles apart, with rdata matching each word in turn.
- Misaligned write: write to 0x42 -> ack with err = 1, word 0x40 unchanged; with DM_BYTE_WR_EN defined, be = 4'b0100 at 0x40, wdata = 0x00AA0000 -> word 0x40 reads 0xDEAABEEF.
- Out of range: read of 0x1000 -> ack with err = 1 and rdata holds its previous value.
- Request change mid-access: addr switched from 0x40 to 0x80 and req dropped during WAIT -> access still goes to 0x40 and ack still pulses once.
